// File: rtl/mac_cluster_seq.sv
// Job sequencer for one mac_cluster: CONFIG (cset) -> RUN (stream beats) -> DRAIN -> DONE. MAC_SEQ_PERF_EN adds stall/job counters.
// Latency: res_valid from t(2+len+PIPE_LAT) with continuous operands; op and result ports are valid/ready, bubbles freeze the cluster.
module mac_cluster_seq #(
    parameter int MAC_CONF_WIDTH = 4,
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_ACC_WIDTH  = 32,
    parameter int LEN_WIDTH      = 8,
    parameter int PIPE_LAT       = 3
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     job_valid,
    output logic                                     job_ready,
    input  logic [4*MAC_ACC_WIDTH+MAC_CONF_WIDTH-1:0] job_cfg,
    input  logic [LEN_WIDTH-1:0]                     job_len,
    input  logic                                     op_valid,
    output logic                                     op_ready,
    input  logic [4*MAC_MIN_WIDTH-1:0]               op_a,
    input  logic [4*MAC_MIN_WIDTH-1:0]               op_b,
    output logic                                     mac_en,
    output logic                                     mac_cset,
    output logic [4*MAC_ACC_WIDTH+MAC_CONF_WIDTH-1:0] mac_cfg,
    output logic [4*MAC_MIN_WIDTH-1:0]               mac_a,
    output logic [4*MAC_MIN_WIDTH-1:0]               mac_b,
    input  logic [4*MAC_ACC_WIDTH-1:0]               mac_out,
    output logic                                     res_valid,
    input  logic                                     res_ready,
    output logic [4*MAC_ACC_WIDTH-1:0]               res_data,
    output logic                                     busy
`ifdef MAC_SEQ_PERF_EN
    ,
    output logic [31:0]                              perf_stall,
    output logic [15:0]                              perf_jobs
`endif
);

    localparam int CFG_W = 4*MAC_ACC_WIDTH + MAC_CONF_WIDTH;
    localparam int OP_W  = 4*MAC_MIN_WIDTH;
    localparam int RES_W = 4*MAC_ACC_WIDTH;
    localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] beat_q,  beat_d;
    logic [DRN_W-1:0]     drain_q, drain_d;
    logic [CFG_W-1:0]     cfg_q,   cfg_d;
    logic [RES_W-1:0]     res_q,   res_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            drain_q <= '0;
            cfg_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            drain_q <= drain_d;
            cfg_q   <= cfg_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        drain_d   = drain_q;
        cfg_d     = cfg_q;
        res_d     = res_q;
        job_ready = 1'b0;
        op_ready  = 1'b0;
        mac_en    = 1'b0;
        mac_cset  = 1'b0;
        mac_a     = '0;
        mac_b     = '0;
        res_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                job_ready = 1'b1;
                if (job_valid) begin
                    cfg_d   = job_cfg;
                    beat_d  = job_len;
                    state_d = S_CONFIG;
                end
            end
            S_CONFIG: begin
                mac_cset = 1'b1;
                // An empty job reports its initial accumulators unchanged.
                if (beat_q == '0) begin
                    res_d   = cfg_q[CFG_W-1:MAC_CONF_WIDTH];
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                op_ready = 1'b1;
                mac_a    = op_a;
                mac_b    = op_b;
                mac_en   = op_valid;
                if (op_valid) begin
                    beat_d = beat_q - 1'b1;
                    if (beat_q == LEN_WIDTH'(1)) begin
                        drain_d = DRAIN_LOAD;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Zero operands push the last real beat out; the final cycle captures with en low.
                if (drain_q != '0) begin
                    mac_en  = 1'b1;
                    drain_d = drain_q - 1'b1;
                end else begin
                    res_d   = mac_out;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mac_cfg  = cfg_q;
    assign res_data = res_q;
    assign busy     = (state_q != S_IDLE);

`ifdef MAC_SEQ_PERF_EN
    logic [31:0] stall_q;
    logic [15:0] jobs_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
            jobs_q  <= '0;
        end else begin
            if (state_q == S_RUN && !op_valid && stall_q != '1) begin
                stall_q <= stall_q + 1'b1;
            end
            if (state_q == S_DONE && res_ready && jobs_q != '1) begin
                jobs_q <= jobs_q + 1'b1;
            end
        end
    end

    assign perf_stall = stall_q;
    assign perf_jobs  = jobs_q;
`endif

endmodule

// File: tb/tb_mac_cluster_seq.sv
// Bench for mac_cluster_seq with a stand-in signed MAC cluster on the mac_* pins.
// Expected results are queued per job and compared at each result handshake.
module tb_mac_cluster_seq;

    localparam int CW    = 4;
    localparam int MW    = 8;
    localparam int AW    = 32;
    localparam int LW    = 8;
    localparam int PL    = 3;
    localparam int CFG_W = 4*AW + CW;
    localparam int OPW   = 4*MW;
    localparam int RW    = 4*AW;

    logic             clk = 1'b0;
    logic             rst;
    logic             job_valid, job_ready;
    logic [CFG_W-1:0] job_cfg;
    logic [LW-1:0]    job_len;
    logic             op_valid, op_ready;
    logic [OPW-1:0]   op_a, op_b;
    logic             mac_en, mac_cset;
    logic [CFG_W-1:0] mac_cfg;
    logic [OPW-1:0]   mac_a, mac_b;
    logic [RW-1:0]    mac_out;
    logic             res_valid, res_ready;
    logic [RW-1:0]    res_data;
    logic             busy;
`ifdef MAC_SEQ_PERF_EN
    logic [31:0]      perf_stall;
    logic [15:0]      perf_jobs;
`endif

    always #5 clk = ~clk;

    mac_cluster_seq #(
        .MAC_CONF_WIDTH(CW), .MAC_MIN_WIDTH(MW), .MAC_ACC_WIDTH(AW),
        .LEN_WIDTH(LW), .PIPE_LAT(PL)
    ) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_cfg(job_cfg), .job_len(job_len),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .mac_en(mac_en), .mac_cset(mac_cset), .mac_cfg(mac_cfg),
        .mac_a(mac_a), .mac_b(mac_b), .mac_out(mac_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy)
`ifdef MAC_SEQ_PERF_EN
        , .perf_stall(perf_stall), .perf_jobs(perf_jobs)
`endif
    );

    // Stand-in cluster: product registered, delayed, then accumulated; PL enabled edges input-to-out.
    logic signed [AW-1:0] c_acc  [4];
    logic signed [AW-1:0] c_pipe [PL-1][4];

    function automatic logic signed [AW-1:0] lane_mul(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic signed [AW-1:0] sa, sb;
        sa = AW'($signed(a));
        sb = AW'($signed(b));
        return sa * sb;
    endfunction

    always @(posedge clk) begin
        if (mac_cset) begin
            for (int i = 0; i < 4; i++) begin
                c_acc[i] <= mac_cfg[CW+AW*i +: AW];
                for (int s = 0; s < PL-1; s++) c_pipe[s][i] <= '0;
            end
        end else if (mac_en) begin
            for (int i = 0; i < 4; i++) begin
                c_pipe[0][i] <= lane_mul(mac_a[MW*i +: MW], mac_b[MW*i +: MW]);
                for (int s = 1; s < PL-1; s++) c_pipe[s][i] <= c_pipe[s-1][i];
                c_acc[i] <= c_acc[i] + c_pipe[PL-2][i];
            end
        end
    end

    assign mac_out = {c_acc[3], c_acc[2], c_acc[1], c_acc[0]};

    int            total = 0;
    int            bad   = 0;
    logic [RW-1:0] exp_q [$];
    logic          en_log   [64];
    logic          cset_log [64];
    int            cset_cnt, en_cnt, rv_first;

    task automatic check_val(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CFG_W-1:0] mkcfg(input int i3, input int i2, input int i1, input int i0);
        return {AW'(i3), AW'(i2), AW'(i1), AW'(i0), 4'b0001};
    endfunction

    // Called at a rising edge in IDLE; returns at the rising edge after the result handshake.
    task automatic run_job(input logic [CFG_W-1:0] cfg, input logic [LW-1:0] len,
                           input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                           input logic [15:0] vpat, input int npat, input int hold, input bit jv_hold);
        logic [RW-1:0] e, held;
        int rvf;
        bit hs;
        for (int i = 0; i < 4; i++) begin
            int init, ai, bi;
            init = int'(cfg[CW+AW*i +: AW]);
            ai   = int'($signed(a[MW*i +: MW]));
            bi   = int'($signed(b[MW*i +: MW]));
            e[AW*i +: AW] = AW'(init + int'(len) * ai * bi);
        end
        exp_q.push_back(e);
        rvf = -1; hs = 1'b0; held = '0; cset_cnt = 0; en_cnt = 0;
        for (int k = 0; k < 64 && !hs; k++) begin
            #1;
            job_valid = (k == 0) || (jv_hold && rvf >= 0);
            job_cfg   = cfg;
            job_len   = len;
            op_a      = a;
            op_b      = b;
            op_valid  = (k >= 2 && k - 2 < npat) ? vpat[k-2] : 1'b0;
            if (res_valid && rvf < 0) begin
                rvf  = k;
                held = res_data;
            end
            res_ready = res_valid && (k >= rvf + hold);
            #1;
            if (k == 0) begin
                check_val("ready_at_accept", RW'(job_ready), RW'(1));
                check_val("busy_at_accept", RW'(busy), RW'(0));
            end
            en_log[k]   = mac_en;
            cset_log[k] = mac_cset;
            if (mac_cset) cset_cnt++;
            if (mac_en) en_cnt++;
            if (res_valid) check_val("job_ready_in_done", RW'(job_ready), RW'(0));
            if (res_valid && k > rvf) check_val("res_data_stable", res_data, held);
            if (res_valid && res_ready) begin
                if (exp_q.size() > 0) check_val("res_data", res_data, exp_q.pop_front());
                else check_val("sb_underflow", RW'(exp_q.size()), RW'(1));
                hs = 1'b1;
            end
            @(posedge clk);
        end
        check_val("handshake_seen", RW'(hs), RW'(1));
        rv_first = rvf;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] p;
        rst = 1'b0; job_valid = 1'b0; job_cfg = '0; job_len = '0;
        op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;

        // 1: reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_val("rst_job_ready", RW'(job_ready), RW'(1));
        check_val("rst_res_valid", RW'(res_valid), RW'(0));
        check_val("rst_mac_en", RW'(mac_en), RW'(0));
        check_val("rst_mac_cset", RW'(mac_cset), RW'(0));
        check_val("rst_busy", RW'(busy), RW'(0));
        check_val("rst_op_ready", RW'(op_ready), RW'(0));
        check_val("rst_res_data", res_data, RW'(0));
        check_val("rst_mac_cfg", RW'(mac_cfg), RW'(0));
        @(posedge clk);

        // 2: continuous operands, len 4
        run_job(mkcfg(0, 0, 0, 0), 8'd4, {4{8'd3}}, {4{8'd5}}, 16'h000F, 4, 0, 1'b0);
        check_val("t2_cset_cycles", RW'(cset_cnt), RW'(1));
        check_val("t2_cset_t1", RW'(cset_log[1]), RW'(1));
        for (int k = 0; k <= 8; k++)
            check_val($sformatf("t2_en_t%0d", k), RW'(en_log[k]), RW'(k >= 2 && k <= 1 + 4 + PL - 1));
        check_val("t2_res_valid_t", RW'(rv_first), RW'(2 + 4 + PL));

        // 3: bubbles 1,0,1,0,1 with len 3
        p = 16'h0015;
        run_job(mkcfg(0, 0, 0, 0), 8'd3, {4{8'd3}}, {4{8'd5}}, p, 5, 0, 1'b0);
        for (int k = 2; k <= 9; k++)
            check_val($sformatf("t3_en_t%0d", k), RW'(en_log[k]), RW'((k <= 6) ? p[k-2] : (k <= 8)));
        check_val("t3_res_valid_t", RW'(rv_first), RW'(10));
`ifdef MAC_SEQ_PERF_EN
        #1;
        check_val("t3_perf_stall", RW'(perf_stall), RW'(2));
        check_val("t3_perf_jobs", RW'(perf_jobs), RW'(2));
        @(posedge clk);
`endif

        // 4: empty job returns initial accumulators
        run_job(mkcfg(32'h44, 32'h33, 32'h22, 32'h11), 8'd0, '0, '0, 16'h0, 0, 0, 1'b0);
        check_val("t4_en_count", RW'(en_cnt), RW'(0));
        check_val("t4_res_valid_t", RW'(rv_first), RW'(2));

        // 5: result backpressure with job_valid held, then back-to-back accept
        run_job(mkcfg(400, 300, 200, 100), 8'd2, {8'hFE, 8'd7, 8'd1, 8'd2}, {8'd9, 8'hFD, 8'd4, 8'd6},
                16'h0003, 2, 5, 1'b1);
        check_val("t5_res_valid_t", RW'(rv_first), RW'(2 + 2 + PL));
        run_job(mkcfg(-7, 0, 1, 2), 8'd1, {8'd2, 8'd3, 8'd4, 8'hFF}, {8'd10, 8'd11, 8'd12, 8'd13},
                16'h0001, 1, 0, 1'b0);

        // 6: reset mid-RUN after 2 of 4 beats
        #1;
        job_valid = 1'b1; job_cfg = mkcfg(5, 5, 5, 5); job_len = 8'd4; op_valid = 1'b0;
        op_a = {4{8'd1}}; op_b = {4{8'd1}}; res_ready = 1'b0;
        @(posedge clk);
        #1 job_valid = 1'b0;
        @(posedge clk);
        #1 op_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 op_valid = 1'b0; rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1; op_valid = 1'b1;
        #1;
        check_val("t6_job_ready", RW'(job_ready), RW'(1));
        check_val("t6_op_ready", RW'(op_ready), RW'(0));
        check_val("t6_mac_en", RW'(mac_en), RW'(0));
        check_val("t6_busy", RW'(busy), RW'(0));
        check_val("t6_res_data", res_data, RW'(0));
`ifdef MAC_SEQ_PERF_EN
        check_val("t6_perf_stall", RW'(perf_stall), RW'(0));
        check_val("t6_perf_jobs", RW'(perf_jobs), RW'(0));
`endif
        op_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #2 check_val($sformatf("t6_no_result_%0d", k), RW'(res_valid), RW'(0));
        end
        @(posedge clk);
        run_job(mkcfg(-10, 0, 7, 1000), 8'd4, {8'd1, 8'h80, 8'd127, 8'd2}, {8'd3, 8'd1, 8'hFF, 8'd50},
                16'h000F, 4, 0, 1'b0);

        check_val("sb_left", RW'(exp_q.size()), RW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
